// File: rtl/rcpt_ptw_walker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rcpt_ptw_walker_if : PTE memory read port used by the walker.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface rcpt_ptw_walker_if #(
  parameter int ADDR_WIDTH = 35
) ();
  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memGnt;
  logic                  memValid;
  logic [63:0]           memData;

  modport master (
    output memReq,
    output memAddr,
    input  memGnt,
    input  memValid,
    input  memData
  );

  modport slave (
    input  memReq,
    input  memAddr,
    output memGnt,
    output memValid,
    output memData
  );
endinterface
`default_nettype wire

// File: rtl/rcpt_ptw_walker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rcpt_ptw_walker : page-table walker filling the MMU TLB on a miss. |
// | Optional WAIT watchdog enabled by defining PTW_TIMEOUT_EN.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rcpt_ptw_walker #(
  parameter  int ADDR_WIDTH  = 35,
  parameter  int TLB_ENTRIES = 32,
  parameter  int VPN_WIDTH   = 23,
  parameter  int PTE_LOG2    = 1,
  parameter  int TIMEOUT     = 255,
  localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_rst_n,
  input  wire logic [ADDR_WIDTH-1:0] i_ptBase,
  input  wire logic                  i_miss,
  input  wire logic [ADDR_WIDTH-1:0] i_missVA,
  output logic                       o_missAck,
  output logic                       o_fault,
  output logic                       o_busy,
  rcpt_ptw_walker_if.master          mem_bus,
  output logic                       o_ptwUpdate,
  output logic [63:0]                o_ptwPTE,
  output logic [IDX_W-1:0]           o_indexVictim
);

  localparam int c_BEAT_W    = (PTE_LOG2 > 0) ? PTE_LOG2 : 1;
  localparam int c_LAST_BEAT = (1 << PTE_LOG2) - 1;

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_REQ  = 3'd1;
  localparam logic [2:0] c_ST_WAIT = 3'd2;
  localparam logic [2:0] c_ST_UPD  = 3'd3;
  localparam logic [2:0] c_ST_DONE = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [c_BEAT_W-1:0]   r_beat;
  logic [63:0]           r_pte;
  logic                  r_fault;
  logic [IDX_W-1:0]      r_victim;

  logic [VPN_WIDTH-1:0]  w_vpn;
  logic [VPN_WIDTH-1:0]  w_vpn_grp;
  logic [ADDR_WIDTH-1:0] w_walk_addr;
  logic                  w_last_beat;
  logic                  w_pte_ok;
  logic                  w_timeout;
  logic                  w_unused;

  // First PTE of the aligned group: base + 8 * (VPN with the group bits cleared).
  assign w_vpn       = i_missVA[ADDR_WIDTH-1 -: VPN_WIDTH];
  assign w_vpn_grp   = (w_vpn >> PTE_LOG2) << PTE_LOG2;
  assign w_walk_addr = i_ptBase + ADDR_WIDTH'({w_vpn_grp, 3'b000});
  assign w_last_beat = (r_beat == c_BEAT_W'(c_LAST_BEAT));
  assign w_pte_ok    = mem_bus.memData[0];
  assign w_unused    = ^{i_missVA[ADDR_WIDTH-VPN_WIDTH-1:0], TIMEOUT[0]};

`ifdef PTW_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT + 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == c_ST_WAIT) && !mem_bus.memValid) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == c_ST_WAIT) && !mem_bus.memValid &&
                     (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (i_miss) w_next = c_ST_REQ;
      end
      c_ST_REQ: begin
        if (mem_bus.memGnt) w_next = c_ST_WAIT;
      end
      c_ST_WAIT: begin
        // Data in the grant cycle never reaches here: the grant cycle is spent in REQ.
        if (mem_bus.memValid) begin
          w_next = w_pte_ok ? c_ST_UPD : c_ST_DONE;
        end else if (w_timeout) begin
          w_next = c_ST_DONE;
        end
      end
      c_ST_UPD: begin
        w_next = w_last_beat ? c_ST_DONE : c_ST_REQ;
      end
      c_ST_DONE: begin
        w_next = c_ST_IDLE;
      end
      default: begin
        w_next = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_beat   <= '0;
      r_pte    <= '0;
      r_fault  <= 1'b0;
      r_victim <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (i_miss) begin
            r_addr  <= w_walk_addr;
            r_beat  <= '0;
            r_fault <= 1'b0;
          end
        end
        c_ST_WAIT: begin
          if (mem_bus.memValid) begin
            r_pte <= mem_bus.memData;
            if (!w_pte_ok) r_fault <= 1'b1;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
          end
        end
        c_ST_UPD: begin
          // Power-of-two depth, so the natural wrap gives the modulo.
          r_victim <= r_victim + 1'b1;
          if (!w_last_beat) begin
            r_beat <= r_beat + 1'b1;
            r_addr <= r_addr + ADDR_WIDTH'(8);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    mem_bus.memReq  = 1'b0;
    mem_bus.memAddr = '0;
    o_ptwUpdate     = 1'b0;
    o_ptwPTE        = '0;
    o_indexVictim   = '0;
    o_missAck       = 1'b0;
    o_fault         = 1'b0;
    o_busy          = (r_state != c_ST_IDLE);
    case (r_state)
      c_ST_REQ: begin
        mem_bus.memReq  = 1'b1;
        mem_bus.memAddr = r_addr;
      end
      c_ST_UPD: begin
        o_ptwUpdate   = 1'b1;
        o_ptwPTE      = r_pte;
        o_indexVictim = r_victim;
      end
      c_ST_DONE: begin
        o_missAck = 1'b1;
        o_fault   = r_fault;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rcpt_ptw_walker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rcpt_ptw_walker : directed table, corner sequences and random   |
// | walks checked against a queue-based walk model. Rev 1.0            |
// +--------------------------------------------------------------------+
module tb_rcpt_ptw_walker;
  localparam int AW  = 35;
  localparam int N   = 2;
  localparam int TLB = 32;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] va;
    int            gl;
    int            vl;
    logic [63:0]   pte0;
    logic [63:0]   pte1;
    logic [AW-1:0] exp_addr;
    int            exp_nrd;
    int            exp_nupd;
    int            exp_idx0;
    int            exp_fault;
    int            exp_busy;
  } vec_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [AW-1:0] i_ptBase;
  logic          i_miss;
  logic [AW-1:0] i_missVA;
  logic          o_missAck;
  logic          o_fault;
  logic          o_busy;
  logic          o_ptwUpdate;
  logic [63:0]   o_ptwPTE;
  logic [4:0]    o_indexVictim;

  rcpt_ptw_walker_if #(.ADDR_WIDTH(AW)) mem_if ();

  rcpt_ptw_walker #(
    .ADDR_WIDTH (AW),
    .TLB_ENTRIES(TLB),
    .VPN_WIDTH  (23),
    .PTE_LOG2   (1),
    .TIMEOUT    (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ptBase     (i_ptBase),
    .i_miss       (i_miss),
    .i_missVA     (i_missVA),
    .o_missAck    (o_missAck),
    .o_fault      (o_fault),
    .o_busy       (o_busy),
    .mem_bus      (mem_if),
    .o_ptwUpdate  (o_ptwUpdate),
    .o_ptwPTE     (o_ptwPTE),
    .o_indexVictim(o_indexVictim)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [63:0]   mem_arr [logic [AW-1:0]];
  logic [AW-1:0] got_addr[$];
  int            got_idx[$];
  logic [63:0]   got_pte[$];
  int            got_busy, got_ack, got_fault, stab_err, stray_fault;
  logic [AW-1:0] exp_addr[$];
  int            exp_idx[$];
  logic [63:0]   exp_pte[$];
  int            exp_busy, exp_fault;
  int            model_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] def_pte(input logic [AW-1:0] a);
    return (64'(a) * 64'h0000_0000_9E37_79B9) | 64'd1;
  endfunction

  function automatic logic [63:0] pte_at(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return def_pte(a);
  endfunction

  // Address of PTE k of the group holding VA's page (4 KiB pages, 8-byte PTEs).
  function automatic logic [AW-1:0] walk_addr(input logic [AW-1:0] base, input logic [AW-1:0] va,
                                              input int k);
    longint unsigned vpn, grp;
    vpn = 64'(va) / 4096;
    grp = (vpn / N) * N;
    return AW'(64'(base) + (grp + 64'(k)) * 8);
  endfunction

  task automatic model_walk(input logic [AW-1:0] base, input logic [AW-1:0] va,
                            input int gl, input int vl);
    logic [63:0]   p;
    logic [AW-1:0] a;
    exp_addr.delete();
    exp_idx.delete();
    exp_pte.delete();
    exp_busy  = 1;
    exp_fault = 0;
    for (int k = 0; k < N; k++) begin
      a = walk_addr(base, va, k);
      exp_addr.push_back(a);
      exp_busy += (gl + 1) + (vl + 1);
      p = pte_at(a);
      if (p[0] == 1'b0) begin
        exp_fault = 1;
        break;
      end
      exp_idx.push_back(model_ptr);
      exp_pte.push_back(p);
      exp_busy += 1;
      model_ptr = (model_ptr + 1) % TLB;
    end
  endtask

  // Plays requester and memory for one walk; gl = grant delay, vl = data delay after grant.
  task automatic run_walk(input logic [AW-1:0] base, input logic [AW-1:0] va,
                          input int gl, input int vl);
    int            gcnt, vcnt;
    bit            pend, held;
    logic [AW-1:0] paddr, prev_addr;
    got_addr.delete();
    got_idx.delete();
    got_pte.delete();
    got_busy = 0; got_ack = 0; got_fault = 0; stab_err = 0; stray_fault = 0;
    gcnt = 0; vcnt = 0; pend = 0; held = 0; paddr = '0; prev_addr = '0;
    i_ptBase = base;
    i_missVA = va;
    i_miss   = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge i_clk); #1;
      if (o_busy) got_busy++;
      if (o_ptwUpdate) begin
        got_idx.push_back(int'(o_indexVictim));
        got_pte.push_back(o_ptwPTE);
      end
      if (o_fault && !o_missAck) stray_fault++;
      if (held && (!mem_if.memReq || mem_if.memAddr !== prev_addr)) stab_err++;
      mem_if.memGnt   = 1'b0;
      mem_if.memValid = 1'b0;
      if (pend) begin
        if (vcnt == 0) begin
          mem_if.memValid = 1'b1;
          mem_if.memData  = pte_at(paddr);
          pend = 0;
        end else begin
          vcnt--;
        end
      end
      held = 0;
      if (mem_if.memReq) begin
        if (gcnt < gl) begin
          gcnt++;
          held      = 1;
          prev_addr = mem_if.memAddr;
        end else begin
          mem_if.memGnt = 1'b1;
          gcnt  = 0;
          paddr = mem_if.memAddr;
          got_addr.push_back(mem_if.memAddr);
          pend  = 1;
          vcnt  = vl;
        end
      end
      if (o_missAck) begin
        got_ack   = 1;
        got_fault = int'(o_fault);
        i_miss    = 1'b0;
        break;
      end
    end
    i_miss = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic compare_model(input string name);
    chk({name, "_ack"}, 64'(got_ack), 64'd1);
    chk({name, "_nreads"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      chk($sformatf("%s_addr%0d", name, i), 64'(got_addr[i]), 64'(exp_addr[i]));
    chk({name, "_nupd"}, 64'(got_idx.size()), 64'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      chk($sformatf("%s_idx%0d", name, i), 64'(got_idx[i]), 64'(exp_idx[i]));
      chk($sformatf("%s_pte%0d", name, i), got_pte[i], exp_pte[i]);
    end
    chk({name, "_fault"}, 64'(got_fault), 64'(exp_fault));
    chk({name, "_busy_cycles"}, 64'(got_busy), 64'(exp_busy));
    chk({name, "_req_stable"}, 64'(stab_err), 64'd0);
    chk({name, "_stray_fault"}, 64'(stray_fault), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
    chk({name, "_memReq"}, 64'(mem_if.memReq), 64'd0);
    chk({name, "_memAddr"}, 64'(mem_if.memAddr), 64'd0);
    chk({name, "_update"}, 64'(o_ptwUpdate), 64'd0);
    chk({name, "_pte"}, o_ptwPTE, 64'd0);
    chk({name, "_idx"}, 64'(o_indexVictim), 64'd0);
    chk({name, "_ack"}, 64'(o_missAck), 64'd0);
    chk({name, "_fault"}, 64'(o_fault), 64'd0);
  endtask

  initial begin
    vec_t          vecs[5];
    logic [AW-1:0] base, va;
    logic [63:0]   p;
    int            gl, vl, seen, cnt;

    // {base, va, gl, vl, pte0, pte1, exp_addr, exp_nrd, exp_nupd, exp_idx0, exp_fault, exp_busy}
    vecs[0] = '{35'h1000, 35'h1234, 0, 0, 64'h0000_0004_4321_03ff, 64'h0022_4704_3524_0083,
                35'h1000, 2, 2, 0, 0, 7};
    vecs[1] = '{35'h1000, 35'h6234, 0, 0, 64'h0000_0004_4321_13ff, 64'h0022_4704_3524_1083,
                35'h1030, 2, 2, 2, 0, 7};
    vecs[2] = '{35'h2000, 35'h3000, 0, 0, 64'h0000_0004_4321_03fe, 64'h0022_4704_3524_0083,
                35'h2010, 1, 0, 4, 1, 3};
    vecs[3] = '{35'h2000, 35'h8000, 0, 0, 64'h0000_0000_0000_0fff, 64'h0000_0000_0000_0000,
                35'h2040, 2, 1, 4, 1, 6};
    // Address sum overflows 35 bits; backpressure 5 cycles and data 2 cycles late.
    vecs[4] = '{35'h7_FFFF_FF00, 35'h7_FFFF_F000, 5, 2, 64'h1234_5678_9ABC_DEF1,
                64'h0FED_CBA9_8765_4321, 35'h003FF_FEF0, 2, 2, 5, 0, 21};

    i_rst_n = 1'b0;
    i_miss = 1'b0;
    i_ptBase = '0;
    i_missVA = '0;
    mem_if.memGnt = 1'b0;
    mem_if.memValid = 1'b0;
    mem_if.memData = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("idle_after_reset_busy", 64'(o_busy), 64'd0);

    for (int v = 0; v < 5; v++) begin
      mem_arr.delete();
      mem_arr[vecs[v].exp_addr] = vecs[v].pte0;
      mem_arr[vecs[v].exp_addr + 35'd8] = vecs[v].pte1;
      run_walk(vecs[v].base, vecs[v].va, vecs[v].gl, vecs[v].vl);
      chk($sformatf("vec%0d_ack", v), 64'(got_ack), 64'd1);
      chk($sformatf("vec%0d_nreads", v), 64'(got_addr.size()), 64'(vecs[v].exp_nrd));
      if (got_addr.size() > 0)
        chk($sformatf("vec%0d_addr0", v), 64'(got_addr[0]), 64'(vecs[v].exp_addr));
      if (got_addr.size() > 1)
        chk($sformatf("vec%0d_addr1", v), 64'(got_addr[1]), 64'(vecs[v].exp_addr + 35'd8));
      chk($sformatf("vec%0d_nupd", v), 64'(got_idx.size()), 64'(vecs[v].exp_nupd));
      if (got_idx.size() > 0) begin
        chk($sformatf("vec%0d_idx0", v), 64'(got_idx[0]), 64'(vecs[v].exp_idx0));
        chk($sformatf("vec%0d_pte0", v), got_pte[0], vecs[v].pte0);
      end
      if (got_idx.size() > 1) begin
        chk($sformatf("vec%0d_idx1", v), 64'(got_idx[1]), 64'((vecs[v].exp_idx0 + 1) % TLB));
        chk($sformatf("vec%0d_pte1", v), got_pte[1], vecs[v].pte1);
      end
      chk($sformatf("vec%0d_fault", v), 64'(got_fault), 64'(vecs[v].exp_fault));
      chk($sformatf("vec%0d_busy_cycles", v), 64'(got_busy), 64'(vecs[v].exp_busy));
      chk($sformatf("vec%0d_req_stable", v), 64'(stab_err), 64'd0);
      chk($sformatf("vec%0d_stray_fault", v), 64'(stray_fault), 64'd0);
    end

    // Victim pointer after the table: 2 + 2 + 0 + 1 + 2 updates.
    model_ptr = 7;
    mem_arr.delete();
    for (int w = 0; w < 20 && model_ptr != 31; w++) begin
      base = AW'({$urandom(), $urandom()});
      base[2:0] = 3'b000;
      va = AW'({$urandom(), $urandom()});
      model_walk(base, va, 0, 0);
      run_walk(base, va, 0, 0);
      compare_model($sformatf("fill%0d", w));
    end
    model_walk(35'h4000, 35'h1_0000, 0, 0);
    run_walk(35'h4000, 35'h1_0000, 0, 0);
    compare_model("wrap");
    if (got_idx.size() > 1) begin
      chk("wrap_first_idx", 64'(got_idx[0]), 64'd31);
      chk("wrap_second_idx", 64'(got_idx[1]), 64'd0);
    end else begin
      chk("wrap_update_count", 64'(got_idx.size()), 64'd2);
    end

    for (int r = 0; r < 30; r++) begin
      base = AW'({$urandom(), $urandom()});
      base[2:0] = 3'b000;
      va = AW'({$urandom(), $urandom()});
      gl = int'($urandom_range(0, 3));
      vl = int'($urandom_range(0, 3));
      mem_arr.delete();
      for (int k = 0; k < N; k++) begin
        p = {$urandom(), $urandom()};
        p[0] = ($urandom_range(0, 4) != 0);
        mem_arr[walk_addr(base, va, k)] = p;
      end
      model_walk(base, va, gl, vl);
      run_walk(base, va, gl, vl);
      compare_model($sformatf("rnd%0d", r));
    end

    // Asynchronous reset while waiting for data; the late response must be dropped.
    mem_arr.delete();
    i_ptBase = 35'h1000;
    i_missVA = 35'h1234;
    i_miss = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      if (mem_if.memReq) begin
        seen = 1;
        break;
      end
    end
    chk("rstwalk_req_seen", 64'(seen), 64'd1);
    mem_if.memGnt = 1'b1;
    @(posedge i_clk); #1;
    mem_if.memGnt = 1'b0;
    chk("rstwalk_busy_in_wait", 64'(o_busy), 64'd1);
    chk("rstwalk_req_dropped", 64'(mem_if.memReq), 64'd0);
    @(posedge i_clk); #1;
    #2 i_rst_n = 1'b0;
    #1;
    chk_all_zero("midwalk_reset");
    i_miss = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    mem_if.memValid = 1'b1;
    mem_if.memData = 64'h0000_0004_4321_03ff;
    @(posedge i_clk); #1;
    mem_if.memValid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_ptwUpdate || o_busy || o_missAck) cnt++;
      @(posedge i_clk); #1;
    end
    chk("late_valid_ignored", 64'(cnt), 64'd0);
    model_ptr = 0;
    model_walk(35'h1000, 35'h1234, 1, 1);
    run_walk(35'h1000, 35'h1234, 1, 1);
    compare_model("post_reset");

`ifdef PTW_TIMEOUT_EN
    // Watchdog: data never arrives, walk must fault 16 cycles after entering WAIT.
    i_ptBase = 35'h1000;
    i_missVA = 35'h0;
    i_miss = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      if (mem_if.memReq) begin
        seen = 1;
        break;
      end
    end
    chk("tmo_req_seen", 64'(seen), 64'd1);
    mem_if.memGnt = 1'b1;
    @(posedge i_clk); #1;
    mem_if.memGnt = 1'b0;
    cnt = 0;
    seen = 0;
    for (int c = 0; c < 64; c++) begin
      if (o_missAck) begin
        seen = 1;
        chk("tmo_fault", 64'(o_fault), 64'd1);
        break;
      end
      @(posedge i_clk); #1;
      cnt++;
    end
    i_miss = 1'b0;
    chk("tmo_ack_seen", 64'(seen), 64'd1);
    chk("tmo_latency", 64'(cnt), 64'd16);
    @(posedge i_clk); #1;
    mem_if.memValid = 1'b1;
    mem_if.memData = 64'h0000_0000_0000_0fff;
    @(posedge i_clk); #1;
    mem_if.memValid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_ptwUpdate || o_busy) cnt++;
      @(posedge i_clk); #1;
    end
    chk("tmo_late_valid_ignored", 64'(cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
